// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the sensor-over-UART transmit path.
//   seq_state_t          : frame sequencer state encoding (IDLE, SEND, WAIT)
//   FRAME_CYCLES_DEFAULT : clocks the transmitter needs per byte, from sampling
//                          start to accepting the next start
//   IDLE_BYTE            : value presented on the data bus when nothing is sent
//   checksum()           : trailing frame byte, XOR of code and value
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } seq_state_t;

   localparam int         FRAME_CYCLES_DEFAULT = 11;
   localparam logic [7:0] IDLE_BYTE            = 8'hFF;

   function automatic logic [7:0] checksum(input logic [7:0] code,
                                           input logic [7:0] value);
      return code ^ value;
   endfunction

endpackage

// File: rtl/uart_tx_frame_sequencer_if.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_sequencer_if
// Request and transmitter-side signals of the frame sequencer.
//   req       : request pulse, sampled while the sequencer is idle
//   cmd_code  : response code byte (frame byte 0)
//   value     : measured sensor value (frame byte 1)
//   tx_start  : one-cycle start strobe to the transmitter
//   tx_data   : byte to the transmitter; index 7 carries byte bit 0, which the
//               transmitter shifts out first
//   busy      : high from request acceptance until done
//   done      : one-cycle pulse when the last byte slot has elapsed
//   overrun   : one-cycle pulse for each cycle req is seen while busy
// Modports: master = requester side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface uart_tx_frame_sequencer_if;

   logic       req;
   logic [7:0] cmd_code;
   logic [7:0] value;
   logic       tx_start;
   logic [0:7] tx_data;
   logic       busy;
   logic       done;
   logic       overrun;

   modport master (
      output req, cmd_code, value,
      input  tx_start, tx_data, busy, done, overrun
   );

   modport slave (
      input  req, cmd_code, value,
      output tx_start, tx_data, busy, done, overrun
   );

endinterface

// File: rtl/uart_tx_frame_sequencer.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_sequencer
// Serialises one sensor response into a frame of bytes (code, value and, when
// CHECKSUM_EN is set, code^value) for a downstream UART transmitter that has
// no busy output. Bytes are paced purely by cycle count: consecutive tx_start
// strobes are exactly FRAME_CYCLES + GAP_CYCLES clocks apart, and tx_data is
// held for the whole slot so it is stable while the transmitter samples it.
//
// Parameters:
//   FRAME_CYCLES : transmitter clocks per byte including recovery
//   GAP_CYCLES   : extra idle clocks between bytes (0..20)
//   CHECKSUM_EN  : 1 = 3-byte frame with checksum, 0 = 2-byte frame
// Ports:
//   clk_115200hz : bit-rate clock shared with the transmitter
//   reset        : asynchronous, active-high; abandons any frame in flight
//   bus          : request / transmitter signals (slave side)
// ----------------------------------------------------------------------------
module uart_tx_frame_sequencer
   import uart_pkg::*;
#(
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
   parameter int GAP_CYCLES   = 1,
   parameter bit CHECKSUM_EN  = 1'b1
) (
   input  logic                        clk_115200hz,
   input  logic                        reset,
   uart_tx_frame_sequencer_if.slave    bus
);

   localparam int SPACING = FRAME_CYCLES + GAP_CYCLES;
   localparam int NBYTES  = CHECKSUM_EN ? 3 : 2;
   localparam int CNT_W   = $clog2(SPACING) + 1;

   // The counter is reloaded on reaching CNT_LAST, so it never wraps.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPACING - 1);
   localparam logic [1:0]       IDX_LAST = 2'(NBYTES - 1);

   seq_state_t       state;
   logic [CNT_W-1:0] counter;
   logic [1:0]       idx;
   logic [7:0]       code_q;
   logic [7:0]       value_q;
   logic [7:0]       csum_q;
   logic [7:0]       next_byte;

   // Byte for the slot after the current one (idx+1). idx never reaches the
   // last slot here, because the last slot ends the frame instead.
   always_comb begin
      // NOTE: default assignment first so no path leaves next_byte unassigned,
      // which would otherwise infer a latch.
      next_byte = csum_q;
      if (idx == 2'd0) begin
         next_byte = value_q;
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values and the block behaves like parallel flops.
   always_ff @(posedge clk_115200hz or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         counter      <= '0;
         idx          <= 2'd0;
         // NOTE: the shadow registers are only read after being loaded, but
         // resetting them keeps the block free of X after reset at no cost.
         code_q       <= 8'h00;
         value_q      <= 8'h00;
         csum_q       <= 8'h00;
         bus.tx_start <= 1'b0;
         bus.tx_data  <= IDLE_BYTE;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.overrun  <= 1'b0;
      end else begin
         // Pulses default low; the branches below raise them for one cycle.
         bus.done    <= 1'b0;
         bus.overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.req) begin
                  code_q       <= bus.cmd_code;
                  value_q      <= bus.value;
                  csum_q       <= checksum(bus.cmd_code, bus.value);
                  // Whole-vector copy: byte bit 0 lands on tx_data[7].
                  bus.tx_data  <= bus.cmd_code;
                  bus.tx_start <= 1'b1;
                  bus.busy     <= 1'b1;
                  idx          <= 2'd0;
                  counter      <= '0;
                  state        <= SEND;
               end
            end

            SEND: begin
               // A request here is dropped just like one during WAIT.
               bus.overrun  <= bus.req;
               bus.tx_start <= 1'b0;
               counter      <= counter + 1'b1;
               state        <= WAIT;
            end

            WAIT: begin
               bus.overrun <= bus.req;
               if (counter == CNT_LAST) begin
                  counter <= '0;
                  if (idx == IDX_LAST) begin
                     bus.done    <= 1'b1;
                     bus.busy    <= 1'b0;
                     bus.tx_data <= IDLE_BYTE;
                     state       <= IDLE;
                  end else begin
                     idx          <= idx + 2'd1;
                     bus.tx_data  <= next_byte;
                     bus.tx_start <= 1'b1;
                     state        <= SEND;
                  end
               end else begin
                  counter <= counter + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_frame_sequencer
// Two sequencer instances: dut_a with the default 3-byte frame and one gap
// clock (byte spacing 12), dut_b with a 2-byte frame and no gap (spacing 11).
// Expected outputs come from a slot-arithmetic model: after the accepting edge
// n, edge n+k lies in slot k/SPACING; a start is expected when k%SPACING==0,
// data is that slot's byte, and done lands on k == NBYTES*SPACING. A simple
// transmitter model on dut_a rebuilds the LSB-first serial bytes and flags any
// start presented while it is still sending.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_frame_sequencer;
   import uart_pkg::*;

   localparam int SP_A = 12;
   localparam int NB_A = 3;
   localparam int SP_B = 11;
   localparam int NB_B = 2;

   logic clk_115200hz = 1'b0;
   logic reset        = 1'b1;

   always #5 clk_115200hz = ~clk_115200hz;

   uart_tx_frame_sequencer_if if_a ();
   uart_tx_frame_sequencer_if if_b ();

   uart_tx_frame_sequencer #(
      .FRAME_CYCLES (11),
      .GAP_CYCLES   (1),
      .CHECKSUM_EN  (1'b1)
   ) dut_a (
      .clk_115200hz (clk_115200hz),
      .reset        (reset),
      .bus          (if_a)
   );

   uart_tx_frame_sequencer #(
      .FRAME_CYCLES (11),
      .GAP_CYCLES   (0),
      .CHECKSUM_EN  (1'b0)
   ) dut_b (
      .clk_115200hz (clk_115200hz),
      .reset        (reset),
      .bus          (if_b)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_start_cyc = 0;

   always @(posedge clk_115200hz) cyc++;

   // ---------------------------------------------------------------- serial
   // Transmitter model for dut_a: after seeing a start it spends 10 clocks on
   // the frame, sampling data bit i (line order) from tx_data[7-i].
   logic [7:0] rx_q[$];
   logic [7:0] ser_byte = 8'h00;
   int         ser_cnt = 0;
   int         ser_collisions = 0;

   always @(negedge clk_115200hz) begin
      if (ser_cnt == 0) begin
         if (if_a.tx_start === 1'b1) ser_cnt = 1;
      end else begin
         if (if_a.tx_start === 1'b1) ser_collisions++;
         if (ser_cnt <= 8) ser_byte[ser_cnt-1] = if_a.tx_data[8-ser_cnt];
         if (ser_cnt == 8) rx_q.push_back(ser_byte);
         ser_cnt = (ser_cnt == 10) ? 0 : ser_cnt + 1;
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic r, input logic [7:0] c,
                        input logic [7:0] v);
      if (sel == 0) begin
         if_a.req = r; if_a.cmd_code = c; if_a.value = v;
      end else begin
         if_b.req = r; if_b.cmd_code = c; if_b.value = v;
      end
   endtask

   // {tx_start, busy, done, overrun, tx_data as a byte value}
   function automatic logic [11:0] obs(input int sel);
      if (sel == 0)
         return {if_a.tx_start, if_a.busy, if_a.done, if_a.overrun, if_a.tx_data};
      return {if_b.tx_start, if_b.busy, if_b.done, if_b.overrun, if_b.tx_data};
   endfunction

   function automatic logic [11:0] model(input int k, input int sp, input int nb,
                                         input logic [2:0][7:0] b, input bit ov);
      bit         active;
      logic [7:0] d;
      active = (k < nb * sp);
      d      = active ? b[k / sp] : IDLE_BYTE;
      return {active && (k % sp == 0), active, (k == nb * sp), ov, d};
   endfunction

   // Requests a frame now (caller is between edges), then checks every edge
   // n..n+NBYTES*SPACING. Inputs are randomised after acceptance; an extra
   // req is driven so that it is sampled at edge n+ov_k (ov_k<1: none).
   task automatic run_frame(input int sel, input logic [7:0] code,
                            input logic [7:0] val, input logic [7:0] b2,
                            input int ov_k, input bit after_chain,
                            input string tag);
      int              sp;
      int              nb;
      logic [2:0][7:0] b;
      logic [11:0]     o;
      sp = (sel == 0) ? SP_A : SP_B;
      nb = (sel == 0) ? NB_A : NB_B;
      b  = {b2, val, code};
      if (sel == 0) rx_q.delete();
      drive(sel, 1'b1, code, val);
      for (int k = 0; k <= nb * sp; k++) begin
         @(posedge clk_115200hz);
         #1;
         o = obs(sel);
         check($sformatf("%s k=%0d {start,busy,done,ovr,data}", tag, k),
               32'(o), 32'(model(k, sp, nb, b, (k == ov_k))));
         if (o[11] === 1'b1 && sel == 0) begin
            if (k == 0 && after_chain)
               check($sformatf("%s back-to-back start gap>=12", tag),
                     32'(cyc - last_start_cyc >= 12), 32'd1);
            last_start_cyc = cyc;
         end
         drive(sel, (k + 1 == ov_k), 8'($urandom), 8'($urandom));
      end
      if (sel == 0) begin
         check($sformatf("%s serial byte count", tag), 32'(rx_q.size()), 32'd3);
         for (int i = 0; i < 3 && i < rx_q.size(); i++)
            check($sformatf("%s serial byte %0d", tag, i), 32'(rx_q[i]), 32'(b[i]));
      end
   endtask

   task automatic idle_check(input int sel, input string tag);
      @(posedge clk_115200hz);
      #1;
      check($sformatf("%s idle after done", tag), 32'(obs(sel)), 32'h0FF);
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      int         sel;
      logic [7:0] code;
      logic [7:0] val;
      logic [7:0] exp_b2;   // expected checksum byte (ignored by dut_b)
      int         ov_k;     // edge offset of an extra req, -1 for none
      bit         chain;    // next vector requests in the done cycle
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [7:0] c;
      logic [7:0] v;
      int         sel;
      int         ovk;
      bool_chain_blk: begin end

      vecs[0] = '{0, 8'hA1, 8'h3C, 8'h9D, -1, 1'b0};
      vecs[1] = '{0, 8'h00, 8'h00, 8'h00, -1, 1'b0};
      vecs[2] = '{0, 8'hFF, 8'hFF, 8'h00, -1, 1'b0};
      vecs[3] = '{0, 8'h5A, 8'hA5, 8'hFF,  5, 1'b0};
      vecs[4] = '{0, 8'h3C, 8'hC3, 8'hFF,  1, 1'b0};
      vecs[5] = '{0, 8'h80, 8'h01, 8'h81, -1, 1'b1};
      vecs[6] = '{0, 8'h12, 8'h34, 8'h26, -1, 1'b0};
      vecs[7] = '{1, 8'h05, 8'hFF, 8'h00, -1, 1'b0};
      vecs[8] = '{1, 8'hC3, 8'h3C, 8'h00, 22, 1'b0};
      vecs[9] = '{0, 8'h7E, 8'h81, 8'hFF, 36, 1'b0};

      drive(0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 8'h00, 8'h00);

      // Reset state while reset is held.
      repeat (3) @(posedge clk_115200hz);
      #1;
      check("reset state dut_a", 32'(obs(0)), 32'h0FF);
      check("reset state dut_b", 32'(obs(1)), 32'h0FF);
      @(negedge clk_115200hz);
      reset = 1'b0;
      repeat (11) @(posedge clk_115200hz);
      #1;

      // Table-driven frames.
      for (int i = 0; i < 10; i++) begin
         run_frame(vecs[i].sel, vecs[i].code, vecs[i].val, vecs[i].exp_b2,
                   vecs[i].ov_k, (i > 0) && vecs[i-1].chain,
                   $sformatf("vec%0d", i));
         if (!vecs[i].chain) idle_check(vecs[i].sel, $sformatf("vec%0d", i));
      end

      // Reset in the middle of the second byte slot.
      drive(0, 1'b1, 8'h6B, 8'h2E);
      @(posedge clk_115200hz);
      #1;
      drive(0, 1'b0, 8'h00, 8'h00);
      repeat (15) @(posedge clk_115200hz);
      #1;
      check("mid-frame busy before reset", 32'(if_a.busy), 32'd1);
      check("mid-frame data before reset", 32'(if_a.tx_data), 32'h2E);
      #1;
      reset = 1'b1;
      #1;
      check("async reset {start,busy,done,ovr,data}", 32'(obs(0)), 32'h0FF);
      repeat (3) @(negedge clk_115200hz);
      reset = 1'b0;
      repeat (11) @(posedge clk_115200hz);
      #1;
      run_frame(0, 8'h6B, 8'h2E, 8'h45, -1, 1'b0, "post-reset");
      idle_check(0, "post-reset");

      // Randomised frames, expected checksum from plain XOR.
      for (int i = 0; i < 12; i++) begin
         sel = (i % 3 == 2) ? 1 : 0;
         c   = 8'($urandom);
         v   = 8'($urandom);
         ovk = -1;
         if ($urandom_range(0, 2) == 0)
            ovk = $urandom_range(1, (sel == 0) ? NB_A * SP_A : NB_B * SP_B);
         run_frame(sel, c, v, c ^ v, ovk, 1'b0, $sformatf("rand%0d", i));
         idle_check(sel, $sformatf("rand%0d", i));
      end

      repeat (12) @(posedge clk_115200hz);
      #1;
      check("transmitter start collisions", 32'(ser_collisions), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
